// File: rtl/region_mean_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : region_mean_feeder_if
// Description : Sample stream, divider handshake and mean result bundle.
// Revision    : 1.0
// ============================================================================
interface region_mean_feeder_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 28,
    parameter int CNT_W  = 20
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_eor;
    logic              in_ready;
    logic              div_start;
    logic [SUM_W-1:0]  div_dividend;
    logic [CNT_W-1:0]  div_divisor;
    logic [SUM_W-1:0]  div_quotient;
    logic              div_qv;
    logic [SUM_W-1:0]  mean;
    logic              mean_valid;
    logic [2:0]        status;

    // slave is the feeder itself; master is the surrounding stream and divider
    modport slave (
        input  in_valid, in_data, in_eor, div_quotient, div_qv,
        output in_ready, div_start, div_dividend, div_divisor, mean, mean_valid, status
    );
    modport master (
        output in_valid, in_data, in_eor, div_quotient, div_qv,
        input  in_ready, div_start, div_dividend, div_divisor, mean, mean_valid, status
    );
endinterface
`default_nettype wire

// File: rtl/region_mean_feeder.sv
`default_nettype none
// ============================================================================
// Module      : region_mean_feeder
// Description : Accumulates a region of samples, issues sum/count to the SAR
//               divider and captures the quotient as the region mean.
//               Define ROUND_EN for a round-half-up mean.
// Revision    : 1.0
// ============================================================================
module region_mean_feeder #(
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 28,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 512
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    region_mean_feeder_if.slave bus
);
    localparam int              TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SUM_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic [SUM_W-1:0]   r_div_dividend;
    logic [CNT_W-1:0]   r_div_divisor;
    logic               r_div_sat;
    logic [TMR_W-1:0]   r_timer;
    logic [SUM_W-1:0]   r_mean;
    logic               r_mean_valid;
    logic [2:0]         r_status;

    logic               w_in_ready;
    logic               w_div_start;
    logic               w_take;
    logic               w_eor;
    logic [SUM_W:0]     w_sum_add;
    logic [SUM_W-1:0]   w_sum_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sat_next;
    logic [SUM_W-1:0]   w_dividend;
    logic               w_div_sat;

    assign w_take    = bus.in_valid && (r_state == S_ACC);
    assign w_eor     = bus.in_eor && (r_state == S_ACC);
    assign w_sum_add = {1'b0, r_sum} + (SUM_W + 1)'(bus.in_data);

    // Saturating accumulate; a sample arriving with eor is folded in here
    always_comb begin
        w_sum_next = r_sum;
        w_cnt_next = r_cnt;
        w_sat_next = r_sat;
        if (w_take) begin
            if (w_sum_add[SUM_W]) begin
                w_sum_next = '1;
                w_sat_next = 1'b1;
            end else begin
                w_sum_next = w_sum_add[SUM_W-1:0];
            end
            if (&r_cnt) begin
                w_sat_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ROUND_EN
    localparam int EXT_W = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
    logic [EXT_W-1:0] w_rnd_ext;

    // Adding half the divisor turns the truncating divide into round-half-up
    always_comb begin
        w_rnd_ext  = EXT_W'(w_sum_next) + EXT_W'(w_cnt_next >> 1);
        w_dividend = w_rnd_ext[SUM_W-1:0];
        w_div_sat  = w_sat_next;
        if (|w_rnd_ext[EXT_W-1:SUM_W]) begin
            w_dividend = '1;
            w_div_sat  = 1'b1;
        end
    end
`else
    always_comb begin
        w_dividend = w_sum_next;
        w_div_sat  = w_sat_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            S_ACC: begin
                w_in_ready = 1'b1;
                if (w_eor) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_div_divisor == '0) begin
                    w_state_next = S_ACC;
                end else begin
                    w_div_start  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.div_qv || (r_timer == C_TMR_LAST)) begin
                    w_state_next = S_ACC;
                end
            end
            default: w_state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum          <= '0;
            r_cnt          <= '0;
            r_sat          <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_sat      <= 1'b0;
            r_timer        <= '0;
            r_mean         <= '0;
            r_mean_valid   <= 1'b0;
            r_status       <= 3'b000;
        end else begin
            r_mean_valid <= 1'b0;
            case (r_state)
                S_ACC: begin
                    if (w_eor) begin
                        r_div_dividend <= w_dividend;
                        r_div_divisor  <= w_cnt_next;
                        r_div_sat      <= w_div_sat;
                        r_sum          <= '0;
                        r_cnt          <= '0;
                        r_sat          <= 1'b0;
                    end else begin
                        r_sum <= w_sum_next;
                        r_cnt <= w_cnt_next;
                        r_sat <= w_sat_next;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    if (r_div_divisor == '0) begin
                        r_mean       <= '0;
                        r_mean_valid <= 1'b1;
                        r_status     <= 3'b010;
                    end
                end
                S_WAIT: begin
                    // A quotient arriving on the last timer cycle still wins
                    if (bus.div_qv) begin
                        r_mean       <= bus.div_quotient;
                        r_mean_valid <= 1'b1;
                        r_status     <= {2'b00, r_div_sat};
                    end else if (r_timer == C_TMR_LAST) begin
                        r_mean       <= '1;
                        r_mean_valid <= 1'b1;
                        r_status     <= 3'b100;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.div_start    = w_div_start;
    assign bus.div_dividend = r_div_dividend;
    assign bus.div_divisor  = r_div_divisor;
    assign bus.mean         = r_mean;
    assign bus.mean_valid   = r_mean_valid;
    assign bus.status       = r_status;

endmodule
`default_nettype wire

// File: tb/tb_region_mean_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_region_mean_feeder
// Description : Scoreboard bench for region_mean_feeder (main and 12-bit sum).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_region_mean_feeder;
    localparam int DATA_W  = 8;
    localparam int SUM_W   = 28;
    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 512;
    localparam int SSUM_W  = 12;

    typedef struct packed {
        logic [SUM_W-1:0] dividend;
        logic [CNT_W-1:0] divisor;
        logic [SUM_W-1:0] mean;
        logic [2:0]       status;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    region_mean_feeder_if #(.DATA_W(DATA_W), .SUM_W(SUM_W),  .CNT_W(CNT_W)) bus ();
    region_mean_feeder_if #(.DATA_W(DATA_W), .SUM_W(SSUM_W), .CNT_W(CNT_W)) sbus ();

    region_mean_feeder #(.DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    region_mean_feeder #(.DATA_W(DATA_W), .SUM_W(SSUM_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    function automatic exp_t model(input int unsigned s[$], input int sw);
        exp_t e;
        longint unsigned sum  = 0;
        longint unsigned cnt  = 0;
        longint unsigned maxs = (64'd1 << sw) - 1;
        longint unsigned maxc = (64'd1 << CNT_W) - 1;
        bit sat = 1'b0;
        foreach (s[i]) begin
            sum = sum + s[i];
            if (sum > maxs) begin sum = maxs; sat = 1'b1; end
            if (cnt == maxc) sat = 1'b1; else cnt = cnt + 1;
        end
`ifdef ROUND_EN
        sum = sum + (cnt >> 1);
        if (sum > maxs) begin sum = maxs; sat = 1'b1; end
`endif
        e.dividend = SUM_W'(sum);
        e.divisor  = CNT_W'(cnt);
        e.mean     = (cnt == 0) ? '0 : SUM_W'(sum / cnt);
        e.status   = (cnt == 0) ? 3'b010 : {2'b00, sat};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_eor = 1'b0;
        bus.div_qv = 1'b0;    bus.div_quotient = '0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_eor = 1'b0;
        sbus.div_qv = 1'b0;   sbus.div_quotient = '0;
    endtask

    // Leaves the DUT in ISSUE: returns right after the edge that took eor
    task automatic send_region(input int unsigned s[$], input bit eor_sep);
        for (int i = 0; i < s.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(s[i]);
            bus.in_eor   = !eor_sep && (i == s.size() - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        if (eor_sep || s.size() == 0) begin
            bus.in_eor = 1'b1;
            tick();
        end
        bus.in_eor = 1'b0;
    endtask

    // Divider model: answers q after dly WAIT cycles, then collects the mean
    task automatic divide_and_collect(input logic [SUM_W-1:0] q, input int dly,
                                      output int starts, output logic [SUM_W-1:0] dvd,
                                      output logic [CNT_W-1:0] dvs, output bit got,
                                      output logic [SUM_W-1:0] m, output logic [2:0] st);
        starts = 0; got = 1'b0; m = '0; st = '0;
        dvd = bus.div_dividend;
        dvs = bus.div_divisor;
        if (bus.div_start) starts++;
        tick();
        for (int i = 0; i < dly; i++) begin
            if (bus.div_start) starts++;
            tick();
        end
        if (bus.div_start) starts++;
        bus.div_quotient = q;
        bus.div_qv = 1'b1;
        tick();
        bus.div_qv = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (bus.mean_valid) begin
                got = 1'b1; m = bus.mean; st = bus.status;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL reset_div_start got=%b exp=0", bus.div_start); end
        n_tests++; if (bus.mean_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mean_valid got=%b exp=0", bus.mean_valid); end
        n_tests++; if (bus.status !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", bus.status); end
        n_tests++; if (bus.mean !== '0) begin n_fail++; $display("FAIL reset_mean got=%0d exp=0", bus.mean); end
        n_tests++; if (bus.div_dividend !== '0 || bus.div_divisor !== '0) begin n_fail++; $display("FAIL reset_div_bus got=%0d/%0d exp=0/0", bus.div_dividend, bus.div_divisor); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_and_check(input string name, input int unsigned s[$], input bit eor_sep, input int dly);
        exp_t e; int starts; bit got;
        logic [SUM_W-1:0] dvd, m; logic [CNT_W-1:0] dvs; logic [2:0] st;
        sb.push_back(model(s, SUM_W));
        send_region(s, eor_sep);
        divide_and_collect(sb[$].mean, dly, starts, dvd, dvs, got, m, st);
        e = sb.pop_front();
        n_tests++; if (dvd !== e.dividend) begin n_fail++; $display("FAIL %s_dividend got=%0d exp=%0d", name, dvd, e.dividend); end
        n_tests++; if (dvs !== e.divisor) begin n_fail++; $display("FAIL %s_divisor got=%0d exp=%0d", name, dvs, e.divisor); end
        n_tests++; if (starts !== 1) begin n_fail++; $display("FAIL %s_start_count got=%0d exp=1", name, starts); end
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL %s_mean_valid got=%b exp=1", name, got); end
        n_tests++; if (m !== e.mean) begin n_fail++; $display("FAIL %s_mean got=%0d exp=%0d", name, m, e.mean); end
        n_tests++; if (st !== e.status) begin n_fail++; $display("FAIL %s_status got=%b exp=%b", name, st, e.status); end
        tick();
        n_tests++; if (bus.mean_valid !== 1'b0) begin n_fail++; $display("FAIL %s_strobe_width got=%b exp=0", name, bus.mean_valid); end
    endtask

    task automatic test_basic();
        int unsigned s[$];
        s.push_back(10); s.push_back(20); s.push_back(30);
        run_and_check("basic", s, 1'b1, 4);
    endtask

    task automatic test_round();
        int unsigned s[$];
        s.push_back(1); s.push_back(2);
        run_and_check("round", s, 1'b0, 0);
    endtask

    task automatic test_empty();
        int unsigned s[$];
        exp_t e;
        sb.push_back(model(s, SUM_W));
        send_region(s, 1'b1);
        n_tests++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL empty_no_start got=%b exp=0", bus.div_start); end
        tick();
        e = sb.pop_front();
        n_tests++; if (bus.mean_valid !== 1'b1) begin n_fail++; $display("FAIL empty_mean_valid got=%b exp=1", bus.mean_valid); end
        n_tests++; if (bus.mean !== e.mean) begin n_fail++; $display("FAIL empty_mean got=%0d exp=%0d", bus.mean, e.mean); end
        n_tests++; if (bus.status !== e.status) begin n_fail++; $display("FAIL empty_status got=%b exp=%b", bus.status, e.status); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_in_ready got=%b exp=1", bus.in_ready); end
        tick();
    endtask

    task automatic test_saturate();
        int unsigned s[$];
        exp_t e;
        for (int i = 0; i < 17; i++) s.push_back(255);
        sb.push_back(model(s, SSUM_W));
        for (int i = 0; i < 17; i++) begin
            sbus.in_valid = 1'b1; sbus.in_data = 8'd255; tick();
        end
        sbus.in_valid = 1'b0; sbus.in_eor = 1'b1; tick();
        sbus.in_eor = 1'b0;
        e = sb.pop_front();
        n_tests++; if (sbus.div_start !== 1'b1) begin n_fail++; $display("FAIL sat_start got=%b exp=1", sbus.div_start); end
        n_tests++; if (sbus.div_dividend !== e.dividend[SSUM_W-1:0]) begin n_fail++; $display("FAIL sat_dividend got=%0d exp=%0d", sbus.div_dividend, e.dividend); end
        n_tests++; if (sbus.div_divisor !== e.divisor) begin n_fail++; $display("FAIL sat_divisor got=%0d exp=%0d", sbus.div_divisor, e.divisor); end
        repeat (2) tick();
        sbus.div_quotient = e.mean[SSUM_W-1:0]; sbus.div_qv = 1'b1; tick();
        sbus.div_qv = 1'b0;
        n_tests++; if (sbus.mean_valid !== 1'b1) begin n_fail++; $display("FAIL sat_mean_valid got=%b exp=1", sbus.mean_valid); end
        n_tests++; if (sbus.mean !== e.mean[SSUM_W-1:0]) begin n_fail++; $display("FAIL sat_mean got=%0d exp=%0d", sbus.mean, e.mean); end
        n_tests++; if (sbus.status !== e.status) begin n_fail++; $display("FAIL sat_status got=%b exp=%b", sbus.status, e.status); end
        tick();
    endtask

    task automatic test_timeout();
        int unsigned s[$];
        exp_t e;
        int lat = 0;
        s.push_back(7); s.push_back(9);
        e = model(s, SUM_W);
        e.mean = '1;
        e.status = 3'b100;
        sb.push_back(e);
        send_region(s, 1'b1);
        while (lat < 600 && bus.mean_valid !== 1'b1) begin
            tick(); lat++;
        end
        e = sb.pop_front();
        n_tests++; if (lat !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TIMEOUT + 1); end
        n_tests++; if (bus.mean !== e.mean) begin n_fail++; $display("FAIL timeout_mean got=%h exp=%h", bus.mean, e.mean); end
        n_tests++; if (bus.status !== e.status) begin n_fail++; $display("FAIL timeout_status got=%b exp=%b", bus.status, e.status); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_in_ready got=%b exp=1", bus.in_ready); end
        tick();
    endtask

    task automatic test_wait_drop();
        int unsigned s[$];
        exp_t e;
        s.push_back(4); s.push_back(6);
        sb.push_back(model(s, SUM_W));
        send_region(s, 1'b0);
        tick();
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_in_ready got=%b exp=0", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_data = 8'd200; bus.in_eor = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0; bus.in_eor = 1'b0;
        bus.div_quotient = sb[$].mean; bus.div_qv = 1'b1;
        tick();
        bus.div_qv = 1'b0;
        e = sb.pop_front();
        n_tests++; if (bus.mean_valid !== 1'b1 || bus.mean !== e.mean) begin n_fail++; $display("FAIL wait_mean got=%b/%0d exp=1/%0d", bus.mean_valid, bus.mean, e.mean); end
        s.delete();
        s.push_back(5); s.push_back(7);
        run_and_check("after_drop", s, 1'b1, 2);
    endtask

    task automatic test_reset_wait();
        int unsigned s[$];
        int spurious = 0;
        s.push_back(9);
        send_region(s, 1'b0);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.div_quotient = 28'd9; bus.div_qv = 1'b1; tick();
        bus.div_qv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mean_valid) spurious++;
            tick();
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL rstwait_no_mean got=%0d exp=0", spurious); end
        n_tests++; if (bus.div_dividend !== '0 || bus.div_divisor !== '0) begin n_fail++; $display("FAIL rstwait_div_bus got=%0d/%0d exp=0/0", bus.div_dividend, bus.div_divisor); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_in_ready got=%b exp=1", bus.in_ready); end
        s.delete();
        s.push_back(3); s.push_back(3);
        run_and_check("after_rst", s, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_empty();
        test_saturate();
        test_timeout();
        test_wait_drop();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
